// File: rtl/uart_ctl_fifo.sv
// rtl/uart_ctl_fifo.sv - UART transmitter and receiver with first-word fall-through RX FIFO
// and sticky parity, framing and overrun flags.
module uart_ctl_fifo #(
  parameter int BAUDRATE  = 9600,
  parameter int FREQ      = 100000000,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int RX_DEPTH  = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      Serial_in,
  output logic                      Serial_out,
  input  logic [DATA_BITS-1:0]      TX_data,
  input  logic                      start_tx,
  output logic                      tx_ready,
  output logic [DATA_BITS-1:0]      RX_data,
  output logic                      rx_valid,
  input  logic                      rx_read,
  output logic [$clog2(RX_DEPTH):0] rx_count,
  output logic                      parity_err,
  output logic                      frame_err,
  output logic                      overrun,
  input  logic                      err_clear
);

  localparam int DIV_RAW = FREQ / (BAUDRATE * 16);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PTR_W   = $clog2(RX_DEPTH);
  localparam int CNT_W   = PTR_W + 1;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [2:0]       LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic             ODD       = (PARITY == 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;

  // Transmitter: its tick divider restarts on acceptance so every bit is exactly 16 ticks.
  state_e               tx_state_q;
  logic [DIV_W-1:0]     tx_div_q;
  logic [3:0]           tx_tick_q;
  logic [DATA_BITS-1:0] tx_shift_q;
  logic [2:0]           tx_bit_q;
  logic                 tx_par_q;
  logic                 tx_stop_q;
  logic                 txd_q;
  logic                 tx_ready_q;
  logic                 tx_tick;
  logic                 tx_bit_end;

  assign tx_tick    = (tx_div_q == DIV_LAST);
  assign tx_bit_end = tx_tick && (tx_tick_q == 4'd15);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state_q <= ST_IDLE;
      tx_div_q   <= '0;
      tx_tick_q  <= '0;
      tx_shift_q <= '0;
      tx_bit_q   <= '0;
      tx_par_q   <= 1'b0;
      tx_stop_q  <= 1'b0;
      txd_q      <= 1'b1;
      tx_ready_q <= 1'b1;
    end else if (tx_state_q == ST_IDLE) begin
      if (start_tx && tx_ready_q) begin
        tx_state_q <= ST_START;
        tx_shift_q <= TX_data;
        tx_par_q   <= (^TX_data) ^ ODD;
        tx_div_q   <= '0;
        tx_tick_q  <= '0;
        tx_bit_q   <= '0;
        tx_stop_q  <= 1'b0;
        txd_q      <= 1'b0;
        tx_ready_q <= 1'b0;
      end
    end else begin
      tx_div_q <= tx_tick ? '0 : tx_div_q + 1'b1;
      if (tx_tick) tx_tick_q <= tx_tick_q + 1'b1;
      if (tx_bit_end) begin
        case (tx_state_q)
          ST_START: begin
            tx_state_q <= ST_DATA;
            txd_q      <= tx_shift_q[0];
          end
          ST_DATA: begin
            if (tx_bit_q == LAST_DATA) begin
              if (PARITY != 0) begin
                tx_state_q <= ST_PARITY;
                txd_q      <= tx_par_q;
              end else begin
                tx_state_q <= ST_STOP;
                txd_q      <= 1'b1;
              end
            end else begin
              tx_bit_q   <= tx_bit_q + 1'b1;
              tx_shift_q <= tx_shift_q >> 1;
              txd_q      <= tx_shift_q[1];
            end
          end
          ST_PARITY: begin
            tx_state_q <= ST_STOP;
            txd_q      <= 1'b1;
          end
          ST_STOP: begin
            if (STOP_BITS == 1 || tx_stop_q) begin
              tx_state_q <= ST_IDLE;
              tx_ready_q <= 1'b1;
            end else begin
              tx_stop_q <= 1'b1;
            end
            txd_q <= 1'b1;
          end
          default: begin
            tx_state_q <= ST_IDLE;
            tx_ready_q <= 1'b1;
            txd_q      <= 1'b1;
          end
        endcase
      end
    end
  end

  assign Serial_out = txd_q;
  assign tx_ready   = tx_ready_q;

  logic sin_s1_q;
  logic sin_s2_q;
  logic sin_prev_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sin_s1_q   <= 1'b1;
      sin_s2_q   <= 1'b1;
      sin_prev_q <= 1'b1;
    end else begin
      sin_s1_q   <= Serial_in;
      sin_s2_q   <= sin_s1_q;
      sin_prev_q <= sin_s2_q;
    end
  end

  // Receiver: divider phase-locks to the start edge, bits sampled on tick 8 of 16.
  state_e               rx_state_q;
  logic [DIV_W-1:0]     rx_div_q;
  logic [3:0]           rx_tick_q;
  logic [DATA_BITS-1:0] rx_shift_q;
  logic [2:0]           rx_bit_q;
  logic                 rx_stop_q;
  logic                 rx_bad_q;
  logic                 push_q;
  logic [DATA_BITS-1:0] push_data_q;
  logic                 pe_set_q;
  logic                 fe_set_q;
  logic                 rx_tick;
  logic                 rx_sample;
  logic                 rx_bit_end;

  assign rx_tick    = (rx_div_q == DIV_LAST);
  assign rx_sample  = rx_tick && (rx_tick_q == 4'd7);
  assign rx_bit_end = rx_tick && (rx_tick_q == 4'd15);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state_q  <= ST_IDLE;
      rx_div_q    <= '0;
      rx_tick_q   <= '0;
      rx_shift_q  <= '0;
      rx_bit_q    <= '0;
      rx_stop_q   <= 1'b0;
      rx_bad_q    <= 1'b0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      pe_set_q    <= 1'b0;
      fe_set_q    <= 1'b0;
    end else begin
      push_q   <= 1'b0;
      pe_set_q <= 1'b0;
      fe_set_q <= 1'b0;
      if (rx_state_q == ST_IDLE) begin
        if (sin_prev_q && !sin_s2_q) begin
          rx_state_q <= ST_START;
          rx_div_q   <= '0;
          rx_tick_q  <= '0;
          rx_bit_q   <= '0;
          rx_stop_q  <= 1'b0;
          rx_bad_q   <= 1'b0;
        end
      end else begin
        rx_div_q <= rx_tick ? '0 : rx_div_q + 1'b1;
        if (rx_tick) rx_tick_q <= rx_tick_q + 1'b1;
        case (rx_state_q)
          ST_START: begin
            if (rx_sample && sin_s2_q) rx_state_q <= ST_IDLE;
            else if (rx_bit_end) rx_state_q <= ST_DATA;
          end
          ST_DATA: begin
            if (rx_sample) rx_shift_q <= {sin_s2_q, rx_shift_q[DATA_BITS-1:1]};
            if (rx_bit_end) begin
              if (rx_bit_q == LAST_DATA) rx_state_q <= (PARITY != 0) ? ST_PARITY : ST_STOP;
              else rx_bit_q <= rx_bit_q + 1'b1;
            end
          end
          ST_PARITY: begin
            if (rx_sample && (sin_s2_q != ((^rx_shift_q) ^ ODD))) begin
              pe_set_q <= 1'b1;
              rx_bad_q <= 1'b1;
            end
            if (rx_bit_end) rx_state_q <= ST_STOP;
          end
          ST_STOP: begin
            if (rx_sample) begin
              if (!sin_s2_q) begin
                fe_set_q   <= 1'b1;
                rx_state_q <= ST_IDLE;
              end else if (STOP_BITS == 1 || rx_stop_q) begin
                rx_state_q <= ST_IDLE;
                if (!rx_bad_q) begin
                  push_q      <= 1'b1;
                  push_data_q <= rx_shift_q;
                end
              end
            end
            if (rx_bit_end) rx_stop_q <= 1'b1;
          end
          default: rx_state_q <= ST_IDLE;
        endcase
      end
    end
  end

  logic [DATA_BITS-1:0] mem_q [RX_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q;
  logic [PTR_W-1:0]     rd_ptr_q;
  logic [CNT_W-1:0]     count_q;
  logic [CNT_W-1:0]     count_d;
  logic                 fifo_full;
  logic                 do_pop;
  logic                 do_push;
  logic                 ovr_set;

  // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
  assign fifo_full = (count_q == CNT_W'(RX_DEPTH));
  assign do_pop    = rx_read && (count_q != '0);
  assign do_push   = push_q && (!fifo_full || do_pop);
  assign ovr_set   = push_q && fifo_full && !do_pop;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_q;
  end

  assign rx_valid = (count_q != '0);
  assign RX_data  = rx_valid ? mem_q[rd_ptr_q] : '0;
  assign rx_count = count_q;

  logic parity_err_q;
  logic frame_err_q;
  logic overrun_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      parity_err_q <= pe_set_q | (parity_err_q & ~err_clear);
      frame_err_q  <= fe_set_q | (frame_err_q & ~err_clear);
      overrun_q    <= ovr_set | (overrun_q & ~err_clear);
    end
  end

  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_ctl_fifo.sv
// tb/tb_uart_ctl_fifo.sv - directed bench: an 8N1 instance for TX and an 8E1 depth-4 instance for RX.
`timescale 1ns/1ps
module tb_uart_ctl_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  int         n_checks = 0;
  int         n_fail   = 0;

  logic       si_n, so_n, start_n, rdy_n, rxv_n, rd_n, pe_n, fe_n, ov_n, clr_n;
  logic [7:0] txd_n, rxd_n;
  logic [2:0] cnt_n;

  logic       si_e, so_e, start_e, rdy_e, rxv_e, rd_e, pe_e, fe_e, ov_e, clr_e;
  logic [7:0] txd_e, rxd_e;
  logic [2:0] cnt_e;

  uart_ctl_fifo #(.BAUDRATE(10000), .FREQ(1600000), .DATA_BITS(8), .PARITY(0),
                  .STOP_BITS(1), .RX_DEPTH(4)) u_dut_n (
    .clk(clk), .reset(reset), .Serial_in(si_n), .Serial_out(so_n),
    .TX_data(txd_n), .start_tx(start_n), .tx_ready(rdy_n),
    .RX_data(rxd_n), .rx_valid(rxv_n), .rx_read(rd_n), .rx_count(cnt_n),
    .parity_err(pe_n), .frame_err(fe_n), .overrun(ov_n), .err_clear(clr_n));

  uart_ctl_fifo #(.BAUDRATE(10000), .FREQ(1600000), .DATA_BITS(8), .PARITY(2),
                  .STOP_BITS(1), .RX_DEPTH(4)) u_dut_e (
    .clk(clk), .reset(reset), .Serial_in(si_e), .Serial_out(so_e),
    .TX_data(txd_e), .start_tx(start_e), .tx_ready(rdy_e),
    .RX_data(rxd_e), .rx_valid(rxv_e), .rx_read(rd_e), .rx_count(cnt_e),
    .parity_err(pe_e), .frame_err(fe_e), .overrun(ov_e), .err_clear(clr_e));

  // Drives one 11-bit 8E1 frame of 160 clk per bit, then 40 clk of idle line.
  task automatic send_frame_e(input logic [7:0] d, input logic par, input logic stop);
    logic [10:0] bits;
    bits = {stop, par, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      si_e = bits[i];
      repeat (160) @(posedge clk);
      #1;
    end
    si_e = 1'b1;
    repeat (40) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (so_n !== 1'b1) begin n_fail++; $display("FAIL reset_serial_out: got %b want 1", so_n); end
    n_checks++; if (rdy_n !== 1'b1) begin n_fail++; $display("FAIL reset_tx_ready: got %b want 1", rdy_n); end
    n_checks++; if (rxv_e !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid: got %b want 0", rxv_e); end
    n_checks++; if (cnt_e !== 3'd0) begin n_fail++; $display("FAIL reset_rx_count: got %0d want 0", cnt_e); end
    n_checks++; if (rxd_e !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data: got %h want 00", rxd_e); end
    n_checks++; if ({pe_e, fe_e, ov_e} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {pe_e, fe_e, ov_e}); end
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_tx_8n1();
    logic [9:0] frame;
    int bad;
    int busy_bad;
    frame = {1'b1, 8'hA5, 1'b0};
    busy_bad = 0;
    txd_n = 8'hA5;
    start_n = 1'b1;
    @(posedge clk);
    #1;
    start_n = 1'b0;
    txd_n = 8'h00;
    for (int b = 0; b < 10; b++) begin
      bad = 0;
      for (int c = 0; c < 160; c++) begin
        if (so_n !== frame[b]) bad++;
        if (rdy_n !== 1'b0) busy_bad++;
        if (b == 4) begin
          start_n = (c == 10);
          txd_n = 8'hFF;
        end
        @(posedge clk);
        #1;
      end
      n_checks++;
      if (bad != 0) begin n_fail++; $display("FAIL tx_a5_bit%0d: %0d of 160 cycles wrong, want level %b", b, bad, frame[b]); end
    end
    n_checks++; if (busy_bad != 0) begin n_fail++; $display("FAIL tx_ready_low_1600: high in %0d cycles, want 0", busy_bad); end
    n_checks++; if (rdy_n !== 1'b1) begin n_fail++; $display("FAIL tx_ready_after_frame: got %b want 1", rdy_n); end
    n_checks++; if (so_n !== 1'b1) begin n_fail++; $display("FAIL tx_idle_line: got %b want 1", so_n); end
  endtask

  task automatic test_rx_8e1();
    send_frame_e(8'h3C, 1'b0, 1'b1);
    n_checks++; if (rxv_e !== 1'b1) begin n_fail++; $display("FAIL rx_3c_valid: got %b want 1", rxv_e); end
    n_checks++; if (rxd_e !== 8'h3C) begin n_fail++; $display("FAIL rx_3c_data: got %h want 3c", rxd_e); end
    n_checks++; if (cnt_e !== 3'd1) begin n_fail++; $display("FAIL rx_3c_count: got %0d want 1", cnt_e); end
    n_checks++; if ({pe_e, fe_e, ov_e} !== 3'b000) begin n_fail++; $display("FAIL rx_3c_flags: got %b want 000", {pe_e, fe_e, ov_e}); end
    rd_e = 1'b1;
    @(posedge clk);
    #1;
    rd_e = 1'b0;
    n_checks++; if (cnt_e !== 3'd0) begin n_fail++; $display("FAIL rx_pop_count: got %0d want 0", cnt_e); end
    n_checks++; if (rxv_e !== 1'b0) begin n_fail++; $display("FAIL rx_pop_valid: got %b want 0", rxv_e); end
    rd_e = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rd_e = 1'b0;
    n_checks++; if (cnt_e !== 3'd0) begin n_fail++; $display("FAIL rx_empty_read_count: got %0d want 0", cnt_e); end
  endtask

  task automatic test_rx_errors();
    send_frame_e(8'h81, 1'b0, 1'b1);
    send_frame_e(8'h3C, 1'b1, 1'b1);
    n_checks++; if (pe_e !== 1'b1) begin n_fail++; $display("FAIL rx_parity_err: got %b want 1", pe_e); end
    n_checks++; if (cnt_e !== 3'd1) begin n_fail++; $display("FAIL rx_parity_count: got %0d want 1", cnt_e); end
    n_checks++; if (rxd_e !== 8'h81) begin n_fail++; $display("FAIL rx_parity_head: got %h want 81", rxd_e); end
    n_checks++; if (fe_e !== 1'b0) begin n_fail++; $display("FAIL rx_parity_no_frame_err: got %b want 0", fe_e); end
    send_frame_e(8'h55, 1'b0, 1'b0);
    n_checks++; if (fe_e !== 1'b1) begin n_fail++; $display("FAIL rx_frame_err: got %b want 1", fe_e); end
    n_checks++; if (cnt_e !== 3'd1) begin n_fail++; $display("FAIL rx_frame_count: got %0d want 1", cnt_e); end
    clr_e = 1'b1;
    rd_e = 1'b1;
    @(posedge clk);
    #1;
    clr_e = 1'b0;
    rd_e = 1'b0;
    n_checks++; if ({pe_e, fe_e} !== 2'b00) begin n_fail++; $display("FAIL rx_err_clear: got %b want 00", {pe_e, fe_e}); end
    n_checks++; if (cnt_e !== 3'd0) begin n_fail++; $display("FAIL rx_err_drain: got %0d want 0", cnt_e); end
  endtask

  task automatic test_overrun();
    logic [4:0] par;
    logic [7:0] d;
    par = 5'b01011;
    for (int i = 0; i < 5; i++) begin
      d = 8'(i + 1);
      send_frame_e(d, par[i], 1'b1);
      if (i == 3) begin
        n_checks++; if (cnt_e !== 3'd4) begin n_fail++; $display("FAIL ovr_full_count: got %0d want 4", cnt_e); end
        n_checks++; if (ov_e !== 1'b0) begin n_fail++; $display("FAIL ovr_not_yet: got %b want 0", ov_e); end
      end
    end
    n_checks++; if (ov_e !== 1'b1) begin n_fail++; $display("FAIL ovr_flag: got %b want 1", ov_e); end
    n_checks++; if (cnt_e !== 3'd4) begin n_fail++; $display("FAIL ovr_count: got %0d want 4", cnt_e); end
    for (int i = 0; i < 4; i++) begin
      d = 8'(i + 1);
      n_checks++; if (rxd_e !== d) begin n_fail++; $display("FAIL ovr_read%0d: got %h want %h", i, rxd_e, d); end
      rd_e = 1'b1;
      @(posedge clk);
      #1;
      rd_e = 1'b0;
    end
    n_checks++; if (cnt_e !== 3'd0) begin n_fail++; $display("FAIL ovr_drained: got %0d want 0", cnt_e); end
    clr_e = 1'b1;
    @(posedge clk);
    #1;
    clr_e = 1'b0;
    n_checks++; if (ov_e !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %b want 0", ov_e); end
  endtask

  task automatic test_glitch();
    si_e = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    si_e = 1'b1;
    repeat (2000) @(posedge clk);
    #1;
    n_checks++; if (cnt_e !== 3'd0) begin n_fail++; $display("FAIL glitch_count: got %0d want 0", cnt_e); end
    n_checks++; if (rxv_e !== 1'b0) begin n_fail++; $display("FAIL glitch_valid: got %b want 0", rxv_e); end
    n_checks++; if ({pe_e, fe_e, ov_e} !== 3'b000) begin n_fail++; $display("FAIL glitch_flags: got %b want 000", {pe_e, fe_e, ov_e}); end
  endtask

  task automatic test_reset_midframe();
    logic [9:0] frame;
    int bad;
    txd_n = 8'hA5;
    start_n = 1'b1;
    @(posedge clk);
    #1;
    start_n = 1'b0;
    repeat (700) @(posedge clk);
    #1;
    n_checks++; if (so_n !== 1'b0) begin n_fail++; $display("FAIL mid_data_bit3: got %b want 0", so_n); end
    reset = 1'b0;
    #1;
    n_checks++; if (so_n !== 1'b1) begin n_fail++; $display("FAIL mid_reset_line: got %b want 1", so_n); end
    n_checks++; if (rdy_n !== 1'b1) begin n_fail++; $display("FAIL mid_reset_ready: got %b want 1", rdy_n); end
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if ({so_n, rdy_n} !== 2'b11) begin n_fail++; $display("FAIL mid_release: got %b want 11", {so_n, rdy_n}); end
    n_checks++; if (cnt_n !== 3'd0) begin n_fail++; $display("FAIL mid_no_partial: got %0d want 0", cnt_n); end
    frame = {1'b1, 8'h3C, 1'b0};
    txd_n = 8'h3C;
    start_n = 1'b1;
    @(posedge clk);
    #1;
    start_n = 1'b0;
    bad = 0;
    for (int k = 0; k < 1600; k++) begin
      if (so_n !== frame[k / 160]) bad++;
      @(posedge clk);
      #1;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL mid_new_frame: %0d cycles wrong, want 0", bad); end
    n_checks++; if (rdy_n !== 1'b1) begin n_fail++; $display("FAIL mid_new_frame_ready: got %b want 1", rdy_n); end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    si_n = 1'b1; start_n = 1'b0; txd_n = 8'h00; rd_n = 1'b0; clr_n = 1'b0;
    si_e = 1'b1; start_e = 1'b0; txd_e = 8'h00; rd_e = 1'b0; clr_e = 1'b0;
    #1;
    test_reset();
    test_tx_8n1();
    test_rx_8e1();
    test_rx_errors();
    test_overrun();
    test_glitch();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
